// File: rtl/bit_serializer.sv
// bit_serializer: buffers WIDTH-bit words in a DEPTH-entry FIFO and emits
// them MSB-first, one bit per clock, as a gap-free serial stream for the
// downstream Mealy encoder. `hold` pauses the stream without losing data.
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
// din_ready is !full, decoded from the registered count only, so it never
// depends on din_valid or on a pop in the same cycle. While full, an offered
// word is ignored even if the serializer pops on that same edge.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             xout,
  output logic             xout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bits_left_q, bits_left_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             xout_q, xout_d;
  logic             xout_valid_q, xout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign full      = (count_q == CW'(DEPTH));
  assign din_ready = !full;
  assign push      = din_valid && !full;
  assign head      = mem[rd_ptr_q];

  // Serializer next state: shift out the current word, or load the FIFO head
  // when idle so the next MSB follows the previous LSB with no gap.
  always_comb begin
    state_d       = state_q;
    bits_left_d   = bits_left_q;
    sr_d          = sr_q;
    xout_d        = 1'b0;
    xout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    pop           = 1'b0;
    if (!hold) begin
      case (state_q)
        SHIFT: begin
          xout_d       = sr_q[WIDTH-1];
          sr_d         = sr_q << 1;
          bits_left_d  = bits_left_q - BW'(1);
          xout_valid_d = 1'b1;
          if (bits_left_q == BW'(1)) state_d = IDLE;
        end
        default: begin
          if (count_q != '0) begin
            pop           = 1'b1;
            xout_d        = head[WIDTH-1];
            sr_d          = head << 1;
            bits_left_d   = BW'(WIDTH - 1);
            xout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            state_d       = SHIFT;
          end
        end
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  // State register with asynchronous reset that drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bits_left_q   <= '0;
      sr_q          <= '0;
      xout_q        <= 1'b0;
      xout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      bits_left_q   <= bits_left_d;
      sr_q          <= sr_d;
      xout_q        <= xout_d;
      xout_valid_q  <= xout_valid_d;
      frame_start_q <= frame_start_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign xout        = xout_q;
  assign xout_valid  = xout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (count_q != '0) || (bits_left_q != '0);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a word/bit queue
// model of the serializer.
module tb_bit_serializer;

  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         hold = 1'b0;
  logic         din_ready, xout, xout_valid, frame_start, busy, state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .hold(hold), .xout(xout),
    .xout_valid(xout_valid), .frame_start(frame_start),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- counters / check ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds queued words; cur_bits holds the unsent bits of the word
  // in flight, MSB first.
  logic [W-1:0] exp_q[$];
  logic         cur_bits[$];
  logic         m_xout = 1'b0, m_xv = 1'b0, m_fs = 1'b0;
  logic         m_accept;
  logic [W-1:0] m_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cur_bits.delete();
      m_xout = 1'b0; m_xv = 1'b0; m_fs = 1'b0;
    end else begin
      m_accept = din_valid && (exp_q.size() < D);
      m_xout = 1'b0; m_xv = 1'b0; m_fs = 1'b0;
      if (!hold) begin
        if (cur_bits.size() == 0 && exp_q.size() != 0) begin
          m_word = exp_q.pop_front();
          for (int b = W - 1; b >= 0; b--) cur_bits.push_back(m_word[b]);
          m_fs = 1'b1;
        end
        if (cur_bits.size() != 0) begin
          m_xout = cur_bits.pop_front();
          m_xv = 1'b1;
        end
      end
      if (m_accept) exp_q.push_back(din);
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic got_bits[$];
  logic got_fs[$];
  int   got_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("xout", xout, m_xout);
      check("xout_valid", xout_valid, m_xv);
      check("frame_start", frame_start, m_fs);
      check("din_ready", din_ready, exp_q.size() < D);
      check("busy", busy, (exp_q.size() != 0) || (cur_bits.size() != 0));
      check("state_dbg", state_dbg, cur_bits.size() != 0);
      if (xout_valid) begin
        got_bits.push_back(xout);
        got_fs.push_back(frame_start);
        got_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [127:0] pack_bits(input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n && i < got_bits.size(); i++) r = {r[126:0], got_bits[i]};
    return r;
  endfunction

  function automatic logic [127:0] pack_fs(input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n && i < got_fs.size(); i++) r = {r[126:0], got_fs[i]};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  int push_edge = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_bits.delete();
    got_fs.delete();
    got_cyc.delete();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    push_edge = cyc;
    din_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 60 && got_bits.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    check("wait_bits", got_bits.size(), n);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] wrap_exp;
  logic         acc;
  int           idx, guard;

  initial begin
    // reset state
    #12;
    check("rst_xout", xout, 1'b0);
    check("rst_xv", xout_valid, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ready", din_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);

    // reset in the middle of a word
    clear_log();
    push_word(8'hA5);
    wait_bits(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_xout", xout, 1'b0);
    check("midrst_xv", xout_valid, 1'b0);
    check("midrst_fs", frame_start, 1'b0);
    check("midrst_ready", din_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    step(12);
    check("midrst_quiet", got_bits.size(), 0);

    // single word: latency, bit order, frame_start placement
    clear_log();
    push_word(8'hB4);
    step(12);
    check("single_n", got_bits.size(), 8);
    check("single_bits", pack_bits(8), 8'hB4);
    check("single_fs", pack_fs(8), 8'h80);
    check("single_lat", got_cyc[0], push_edge + 1);
    check("single_span", got_cyc[7] - got_cyc[0], 7);

    // back-to-back words form one gap-free stream
    clear_log();
    din_valid = 1'b1;
    din = 8'hFF; @(posedge clk); #1;
    din = 8'h00; @(posedge clk); #1;
    din = 8'h81; @(posedge clk); #1;
    din_valid = 1'b0;
    step(30);
    check("b2b_n", got_bits.size(), 24);
    check("b2b_bits", pack_bits(24), 24'hFF0081);
    check("b2b_fs", pack_fs(24), 24'h808080);
    check("b2b_span", got_cyc[23] - got_cyc[0], 23);

    // full FIFO under hold: words 5 and 6 are dropped
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = W'((i + 1) * 8'h11);
      din_valid = 1'b1;
      @(negedge clk);
      check("full_ready", din_ready, i < D);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    step(2);
    check("full_quiet", got_bits.size(), 0);
    hold = 1'b0;
    step(40);
    check("full_n", got_bits.size(), 32);
    check("full_bits", pack_bits(32), 32'h11223344);

    // hold for three cycles after the second bit
    clear_log();
    push_word(8'hC3);
    wait_bits(2);
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    step(12);
    check("hold_n", got_bits.size(), 8);
    check("hold_bits", pack_bits(8), 8'hC3);
    check("hold_fs", pack_fs(8), 8'h80);
    check("hold_gap", got_cyc[2] - got_cyc[1], 4);
    check("hold_span", got_cyc[7] - got_cyc[0], 10);

    // pointer wrap: ten words with din_valid held high
    clear_log();
    idx = 1;
    guard = 0;
    din_valid = 1'b1;
    while (idx <= 10 && guard < 300) begin
      din = W'(idx);
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    din_valid = 1'b0;
    check("wrap_drive", idx, 11);
    step(100);
    wrap_exp = '0;
    for (int k = 1; k <= 10; k++) wrap_exp = {wrap_exp[119:0], W'(k)};
    check("wrap_n", got_bits.size(), 80);
    check("wrap_bits", pack_bits(80), wrap_exp);
    check("wrap_busy", busy, 1'b0);

    // randomized traffic with random hold
    repeat (800) begin
      din = W'($urandom);
      din_valid = ($urandom_range(0, 2) != 0);
      hold = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    hold = 1'b0;
    step(120);
    check("rand_drain_busy", busy, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
